// File: rtl/gpio_sequencer.sv
// gpio_sequencer: plays a CPU-loaded pattern table onto the GPIO peripheral.
// It writes the direction register once, then writes the data register every
// effective STEP cycles. It can loop over the table, and the CPU can abort it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | not running; waits for a CTRL write with run=1
// DIR_WR  | master write of DIRMASK to GPIO 0x00, held until acknowledged
// DATA_WR | master write of pattern[idx] to GPIO 0x04, held until acknowledged
// WAIT    | step timer counts down to 0, then advance, loop, or finish
module gpio_sequencer #(
  parameter int DEPTH = 16,
  parameter int WIDHT = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        response,
  output logic        m_write,
  output logic [31:0] m_address,
  output logic [31:0] m_write_data,
  input  logic        m_response,
  output logic        done_irq
);
  localparam int IDXW = $clog2(DEPTH);
  localparam logic [9:0] DEPTH_W = 10'(DEPTH);

  typedef enum logic [1:0] {IDLE, DIR_WR, DATA_WR, WAIT} state_t;

  state_t           state, state_nxt;
  logic [IDXW-1:0]  idx, idx_nxt;
  logic [23:0]      timer, timer_nxt;
  logic [23:0]      step_reg;
  logic [8:0]       len_reg;
  logic [WIDHT-1:0] dirmask;
  logic             loop_reg;
  logic             done;
  logic [WIDHT-1:0] pattern [DEPTH];

  logic             done_set, done_clr, irq_nxt;
  logic             mw_nxt;
  logic [31:0]      ma_nxt, md_nxt;
  logic             wr_ctrl, wr_step, wr_len, wr_entry, wr_dir;
  logic             busy, start, abort;
  logic [23:0]      eff_step;
  logic [9:0]       eff_len;
  logic             unused_ok;

  assign wr_ctrl  = write && (address[7:0] == 8'h00);
  assign wr_step  = write && (address[7:0] == 8'h04);
  assign wr_len   = write && (address[7:0] == 8'h08);
  assign wr_entry = write && (address[7:0] == 8'h0C);
  assign wr_dir   = write && (address[7:0] == 8'h14);

  assign busy     = (state != IDLE);
  assign eff_step = (step_reg < 24'd2) ? 24'd2 : step_reg;
  assign eff_len  = (10'(len_reg) > DEPTH_W) ? DEPTH_W : 10'(len_reg);
  assign start    = wr_ctrl && write_data[0] && !busy && (eff_len != 10'd0);
  assign abort    = wr_ctrl && !write_data[0] && busy;
  assign response = read | write;

  // Only a few address and data bits are decoded; the rest are don't-care.
  assign unused_ok = ^{address[31:8], write_data};

  // Next-state, index/timer update and the master outputs for the coming cycle.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    timer_nxt = timer;
    done_set  = 1'b0;
    done_clr  = 1'b0;
    irq_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = DIR_WR;
          idx_nxt   = '0;
          done_clr  = 1'b1;
        end
      end
      DIR_WR: begin
        if (m_response) state_nxt = DATA_WR;
      end
      DATA_WR: begin
        if (m_response) begin
          timer_nxt = eff_step - 24'd2;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (timer == 24'd0) begin
          // LENGTH may have been lowered under idx while running; this compare
          // then treats the table as finished.
          if ((10'(idx) + 10'd1) < eff_len) begin
            idx_nxt   = idx + 1'b1;
            state_nxt = DATA_WR;
          end else if (loop_reg) begin
            idx_nxt   = '0;
            state_nxt = DATA_WR;
          end else begin
            state_nxt = IDLE;
            done_set  = 1'b1;
            irq_nxt   = 1'b1;
          end
        end else begin
          timer_nxt = timer - 24'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (abort) begin
      state_nxt = IDLE;
      idx_nxt   = idx;
      timer_nxt = timer;
      done_set  = 1'b0;
      irq_nxt   = 1'b0;
    end

    // Outputs track the next state so m_write lines up with the state itself.
    // A write that is still waiting for its acknowledge keeps its captured data.
    mw_nxt = 1'b0;
    ma_nxt = 32'h0;
    md_nxt = 32'h0;
    case (state_nxt)
      DIR_WR: begin
        mw_nxt = 1'b1;
        ma_nxt = 32'h0;
        md_nxt = (state == DIR_WR) ? m_write_data : 32'(dirmask);
      end
      DATA_WR: begin
        mw_nxt = 1'b1;
        ma_nxt = 32'h4;
        md_nxt = (state == DATA_WR) ? m_write_data : 32'(pattern[idx_nxt]);
      end
      default: ;
    endcase
  end

  // State, sequencing counters, config registers and master port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      timer        <= '0;
      step_reg     <= '0;
      len_reg      <= '0;
      dirmask      <= '0;
      loop_reg     <= 1'b0;
      done         <= 1'b0;
      done_irq     <= 1'b0;
      m_write      <= 1'b0;
      m_address    <= 32'h0;
      m_write_data <= 32'h0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      timer        <= timer_nxt;
      done_irq     <= irq_nxt;
      m_write      <= mw_nxt;
      m_address    <= ma_nxt;
      m_write_data <= md_nxt;
      if (wr_ctrl) loop_reg <= write_data[1];
      if (wr_step) step_reg <= write_data[23:0];
      if (wr_len)  len_reg  <= write_data[8:0];
      if (wr_dir)  dirmask  <= write_data[WIDHT-1:0];
      if (done_clr)      done <= 1'b0;
      else if (done_set) done <= 1'b1;
    end
  end

  // Pattern table, written one entry at a time through ENTRY.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pattern[i] <= '0;
    end else if (wr_entry) begin
      pattern[write_data[24 +: IDXW]] <= write_data[WIDHT-1:0];
    end
  end

  // Combinational readback, forced to zero outside a read strobe.
  always_comb begin
    read_data = 32'h0;
    if (read) begin
      case (address[7:0])
        8'h00:   read_data = {30'h0, loop_reg, busy};
        8'h04:   read_data = {8'h0, step_reg};
        8'h08:   read_data = {23'h0, len_reg};
        8'h10:   read_data = {16'h0, 8'(idx), 6'h0, done, busy};
        8'h14:   read_data = 32'(dirmask);
        default: read_data = 32'h0;
      endcase
    end
  end
endmodule
